// File: rtl/tm1638_responder.sv
// Device-side TM1638 responder: oversamples STB/CLK/DIO, decodes commands, holds the
// display RAM and display control, and shifts the 4 key-scan bytes back out on DIO.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic         stb_in,
    input  logic         clk_in,
    input  logic         dio_in,
    output logic         dio_out,
    output logic         dio_oe,
    input  logic [31:0]  key_in,
    output logic [127:0] disp_ram,
    output logic         disp_on,
    output logic [2:0]   brightness,
    output logic         cmd_valid,
    output logic [7:0]   cmd_byte
);

    // state     | meaning
    // S_IDLE    | STB high or frame not yet started
    // S_CMD     | receiving the first (command) byte of a frame
    // S_WR_DATA | following bytes go to display RAM
    // S_RD_DATA | shifting key-scan bits out on CLK falls
    // S_IGNORE  | rest of frame carries nothing we act on
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_DATA,
        S_RD_DATA,
        S_IGNORE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] stb_sync, clk_sync, dio_sync;
    logic       stb_prev, clk_prev;
    logic       stb_s, clk_s, dio_s;
    logic       stb_rise, stb_fall, clk_rise, clk_fall;

    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic [3:0] addr;
    logic       mode_read;
    logic       mode_fixed;
    logic [31:0] tx_reg;
    logic [5:0] tx_cnt;
    logic       cmd_done;
    logic       ram_we;

    always_ff @(posedge mclk) begin
        if (rst) begin
            stb_sync <= '1;
            clk_sync <= '1;
            dio_sync <= '1;
            stb_prev <= 1'b1;
            clk_prev <= 1'b1;
        end else begin
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], stb_in};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], clk_in};
            dio_sync <= {dio_sync[SYNC_STAGES-2:0], dio_in};
            stb_prev <= stb_s;
            clk_prev <= clk_s;
        end
    end

    assign stb_s    = stb_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign dio_s    = dio_sync[SYNC_STAGES-1];
    assign stb_fall = stb_prev & ~stb_s;
    assign stb_rise = ~stb_prev & stb_s;
    // CLK edges only count while STB is low; a CLK rise coinciding with STB rise is dropped.
    assign clk_rise = ~clk_prev & clk_s & ~stb_s;
    assign clk_fall = clk_prev & ~clk_s & ~stb_s;

    assign rx_byte   = {dio_s, shift_reg[7:1]};
    assign byte_done = clk_rise && (bit_cnt == 3'd7) && (state != S_IDLE);

    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_done   = 1'b0;
        ram_we     = 1'b0;
        if (stb_rise) begin
            state_next = S_IDLE;
        end else if (stb_fall) begin
            state_next = S_CMD;
        end else if (byte_done) begin
            case (state)
                S_CMD: begin
                    cmd_done = 1'b1;
                    case (rx_byte[7:6])
                        2'b01:   state_next = (rx_byte[1:0] == 2'b10) ? S_RD_DATA : S_IGNORE;
                        2'b11:   state_next = mode_read ? S_IGNORE : S_WR_DATA;
                        default: state_next = S_IGNORE;
                    endcase
                end
                S_WR_DATA: ram_we = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            addr       <= '0;
            mode_read  <= 1'b0;
            mode_fixed <= 1'b0;
            tx_reg     <= '0;
            tx_cnt     <= '0;
            disp_ram   <= '0;
            disp_on    <= 1'b0;
            brightness <= '0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= '0;
            dio_oe     <= 1'b0;
            dio_out    <= 1'b0;
        end else begin
            cmd_valid <= cmd_done;

            if (stb_fall) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (clk_rise && state != S_IDLE) begin
                bit_cnt   <= bit_cnt + 3'd1;
                shift_reg <= rx_byte;
            end

            if (cmd_done) begin
                cmd_byte <= rx_byte;
                tx_reg   <= key_in;
                tx_cnt   <= '0;
                case (rx_byte[7:6])
                    2'b01: begin
                        mode_read  <= (rx_byte[1:0] == 2'b10);
                        mode_fixed <= rx_byte[2];
                    end
                    2'b10: begin
                        disp_on    <= rx_byte[3];
                        brightness <= rx_byte[2:0];
                    end
                    2'b11:   addr <= rx_byte[3:0];
                    default: ;
                endcase
            end

            if (ram_we) begin
                disp_ram[{addr, 3'b000} +: 8] <= rx_byte;
                if (!mode_fixed) begin
                    addr <= addr + 4'd1;
                end
            end

            // Leaving RD_DATA only happens on an STB edge, so releasing DIO here keeps dio_oe inside RD_DATA.
            if (stb_rise || stb_fall) begin
                dio_oe  <= 1'b0;
                dio_out <= 1'b0;
            end else if (state == S_RD_DATA && clk_fall) begin
                dio_oe <= 1'b1;
                if (tx_cnt != 6'd32) begin
                    dio_out <= tx_reg[0];
                    tx_reg  <= {1'b0, tx_reg[31:1]};
                    tx_cnt  <= tx_cnt + 6'd1;
                end else begin
                    dio_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: acts as the TM1638 master on STB/CLK/DIO and
// checks RAM, display control, key read-back and reset behaviour against hand-computed values.
module tb_tm1638_responder;

    localparam int HOLD = 6;

    logic         mclk = 1'b0;
    logic         rst;
    logic         stb_in;
    logic         clk_in;
    logic         dio_in;
    logic         dio_out;
    logic         dio_oe;
    logic [31:0]  key_in;
    logic [127:0] disp_ram;
    logic         disp_on;
    logic [2:0]   brightness;
    logic         cmd_valid;
    logic [7:0]   cmd_byte;

    int checks   = 0;
    int failures = 0;
    int cv_count = 0;
    logic mdrive   = 1'b0;
    logic conflict = 1'b0;

    logic [127:0] exp_ram;
    logic [7:0]   rd_byte;

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .mclk       (mclk),
        .rst        (rst),
        .stb_in     (stb_in),
        .clk_in     (clk_in),
        .dio_in     (dio_in),
        .dio_out    (dio_out),
        .dio_oe     (dio_oe),
        .key_in     (key_in),
        .disp_ram   (disp_ram),
        .disp_on    (disp_on),
        .brightness (brightness),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte)
    );

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (cmd_valid) cv_count <= cv_count + 1;
        if (mdrive && dio_oe) conflict <= 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic stb_low();
        stb_in = 1'b0;
        wait_cyc(HOLD);
    endtask

    task automatic stb_high();
        wait_cyc(HOLD);
        stb_in = 1'b1;
        wait_cyc(HOLD);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        mdrive = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            clk_in = 1'b0;
            dio_in = b[i];
            wait_cyc(HOLD);
            clk_in = 1'b1;
            wait_cyc(HOLD);
        end
        mdrive = 1'b0;
        dio_in = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic read_byte(output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            clk_in = 1'b0;
            wait_cyc(HOLD);
            clk_in = 1'b1;
            b[i] = dio_out;
            wait_cyc(HOLD);
        end
    endtask

    task automatic one_byte_frame(input logic [7:0] b);
        stb_low();
        send_byte(b);
        stb_high();
    endtask

    initial begin
        rst    = 1'b1;
        stb_in = 1'b1;
        clk_in = 1'b1;
        dio_in = 1'b1;
        key_in = 32'h0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);

        check("reset_disp_ram", disp_ram, 128'h0);
        check("reset_disp_on", disp_on, 0);
        check("reset_brightness", brightness, 0);
        check("reset_dio_oe", dio_oe, 0);
        check("reset_dio_out", dio_out, 0);
        check("reset_cmd_byte", cmd_byte, 0);
        check("reset_cmd_valid", cmd_valid, 0);

        // Auto-increment write of 0..15 starting at address 0
        one_byte_frame(8'h40);
        stb_low();
        send_byte(8'hC0);
        for (int a = 0; a < 16; a++) send_byte(8'(a));
        stb_high();
        for (int a = 0; a < 16; a++) exp_ram[8*a +: 8] = 8'(a);
        check("incr_write_ram", disp_ram, exp_ram);
        check("incr_cmd_valid_count", cv_count, 2);
        check("incr_cmd_byte", cmd_byte, 8'hC0);

        // Fixed-address write: last byte wins at address 5
        one_byte_frame(8'h44);
        stb_low();
        send_byte(8'hC5);
        send_byte(8'hAA);
        send_byte(8'h55);
        stb_high();
        exp_ram[8*5 +: 8] = 8'h55;
        check("fixed_write_ram", disp_ram, exp_ram);

        // Address wrap 0xF -> 0x0
        one_byte_frame(8'h40);
        stb_low();
        send_byte(8'hCF);
        send_byte(8'h11);
        send_byte(8'h22);
        stb_high();
        exp_ram[8*15 +: 8] = 8'h11;
        exp_ram[8*0 +: 8]  = 8'h22;
        check("wrap_write_ram", disp_ram, exp_ram);

        // Display control
        one_byte_frame(8'h8F);
        check("dispctl_8f_on", disp_on, 1);
        check("dispctl_8f_bright", brightness, 7);
        one_byte_frame(8'h80);
        check("dispctl_80_on", disp_on, 0);
        check("dispctl_80_bright", brightness, 0);
        one_byte_frame(8'h8A);
        check("dispctl_8a_on", disp_on, 1);
        check("dispctl_8a_bright", brightness, 2);

        // Command 00 changes nothing
        one_byte_frame(8'h3F);
        check("cmd00_bright", brightness, 2);
        check("cmd00_cmd_byte", cmd_byte, 8'h3F);

        // Key read-back
        key_in = 32'h08040201;
        stb_low();
        send_byte(8'h42);
        check("read_oe_before_first_fall", dio_oe, 0);
        key_in = 32'hFFFFFFFF;
        read_byte(rd_byte);
        check("read_byte0", rd_byte, 8'h01);
        read_byte(rd_byte);
        check("read_byte1", rd_byte, 8'h02);
        read_byte(rd_byte);
        check("read_byte2", rd_byte, 8'h04);
        read_byte(rd_byte);
        check("read_byte3", rd_byte, 8'h08);
        clk_in = 1'b0;
        wait_cyc(HOLD);
        clk_in = 1'b1;
        wait_cyc(HOLD);
        check("read_extra_clk_out", dio_out, 0);
        check("read_extra_clk_oe", dio_oe, 1);
        stb_in = 1'b1;
        wait_cyc(2);
        check("read_oe_held_until_detect", dio_oe, 1);
        wait_cyc(1);
        check("read_oe_released", dio_oe, 0);
        wait_cyc(HOLD);

        // Address set ignored while mode_read is still set
        stb_low();
        send_byte(8'hC7);
        send_byte(8'h99);
        stb_high();
        check("read_mode_blocks_write", disp_ram, exp_ram);

        // Aborted frame: partial byte after address set is discarded
        one_byte_frame(8'h40);
        stb_low();
        send_byte(8'hC0);
        send_bits(8'hFF, 5);
        stb_high();
        check("abort_ram_unchanged", disp_ram, exp_ram);

        // Reset in the middle of a read
        one_byte_frame(8'h8F);
        key_in = 32'hA5A5A5A5;
        stb_low();
        send_byte(8'h42);
        read_byte(rd_byte);
        check("pre_reset_read", rd_byte, 8'hA5);
        clk_in = 1'b0;
        wait_cyc(HOLD);
        check("pre_reset_oe", dio_oe, 1);
        rst = 1'b1;
        wait_cyc(2);
        check("rst_dio_oe", dio_oe, 0);
        check("rst_dio_out", dio_out, 0);
        check("rst_disp_ram", disp_ram, 128'h0);
        check("rst_disp_on", disp_on, 0);
        check("rst_brightness", brightness, 0);
        check("rst_cmd_byte", cmd_byte, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        rst    = 1'b0;
        clk_in = 1'b1;
        stb_in = 1'b1;
        wait_cyc(HOLD);
        check("post_rst_oe", dio_oe, 0);

        // mode_read cleared by reset, so an address set writes again
        stb_low();
        send_byte(8'hC3);
        send_byte(8'h77);
        stb_high();
        exp_ram = '0;
        exp_ram[8*3 +: 8] = 8'h77;
        check("post_rst_write", disp_ram, exp_ram);

        check("no_bus_conflict", conflict, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
